// File: rtl/fwd_scoreboard_if.sv
// Decode-side bundle for the forwarding/hazard unit:
// decoding-instruction fields in, bypass selects and stall status out.
interface fwd_scoreboard_if #(
    parameter int REG_W = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
);
    logic             hold;
    logic             flush;
    logic             id_valid;
    logic             id_regwrite;
    logic             id_load;
    logic [REG_W-1:0] id_dest;
    logic [REG_W-1:0] id_op1;
    logic [REG_W-1:0] id_op2;
    logic             id_use1;
    logic             id_use2;
    logic [SEL_W-1:0] forward_a;
    logic [SEL_W-1:0] forward_b;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output hold, flush, id_valid, id_regwrite, id_load,
        output id_dest, id_op1, id_op2, id_use1, id_use2,
        input  forward_a, forward_b, stall, stall_cnt
    );

    modport slave (
        input  hold, flush, id_valid, id_regwrite, id_load,
        input  id_dest, id_op1, id_op2, id_use1, id_use2,
        output forward_a, forward_b, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Shift-register scoreboard of in-flight destinations: youngest-first
// bypass selects, load-use stall with bubble insertion, stall counter.
module fwd_scoreboard #(
    parameter int REG_W      = 4,
    parameter int STAGES     = 3,
    parameter int LOAD_READY = 1,
    parameter int SEL_W      = $clog2(STAGES + 1),
    parameter int CNT_W      = 16
) (
    input logic            clk,
    input logic            rst_n,
    fwd_scoreboard_if.slave sb_if
);

    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             load;
        logic [REG_W-1:0] dest;
    } ent_t;

    ent_t             sb [STAGES];
    logic [CNT_W-1:0] cnt_q;

    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             hz_a;
    logic             hz_b;
    logic             stall_c;
    logic             accept;

    // Scan oldest to youngest so the youngest match overwrites last.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        hz_a  = 1'b0;
        hz_b  = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (sb[i].valid && sb[i].regwrite &&
                sb[i].dest == sb_if.id_op1 && sb_if.id_use1) begin
                sel_a = SEL_W'(i + 1);
                hz_a  = sb[i].load && (i < LOAD_READY);
            end
            if (sb[i].valid && sb[i].regwrite &&
                sb[i].dest == sb_if.id_op2 && sb_if.id_use2) begin
                sel_b = SEL_W'(i + 1);
                hz_b  = sb[i].load && (i < LOAD_READY);
            end
        end
    end

    assign stall_c = sb_if.id_valid && !sb_if.flush && (hz_a || hz_b);
    assign accept  = sb_if.id_valid && !stall_c && !sb_if.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sb[i] <= '0;
            end
            cnt_q <= '0;
        end else if (!sb_if.hold) begin
            if (accept) begin
                sb[0] <= '{valid:    1'b1,
                           regwrite: sb_if.id_regwrite,
                           load:     sb_if.id_load,
                           dest:     sb_if.id_dest};
            end else begin
                sb[0] <= '0;
            end
            // A flushed EX entry is killed as it moves into MEM.
            for (int i = 1; i < STAGES; i++) begin
                sb[i]       <= sb[i-1];
                sb[i].valid <= sb[i-1].valid && !(sb_if.flush && i == 1);
            end
            if (stall_c && cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign sb_if.forward_a = sel_a;
    assign sb_if.forward_b = sel_b;
    assign sb_if.stall     = stall_c;
    assign sb_if.stall_cnt = cnt_q;

endmodule
